uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Serial-to-parallel receiver for the CPU's byte-wide serial link. Idle-high, LSB-first, start bit, DATA_WIDTH data bits, one stop bit.
- Oversamples the line with a per-bit cycle counter and samples at mid-bit.
- Assembles each word in a shift register and hands it to the core through a valid/ready holding register.
- Sits between the external pin and the I/O register file; it is the receive end that pairs with the team's parallel-load/serial-out transmit path.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 16, clk cycles per serial bit (even, >=4).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, asynchronous, idles high.
- data_out  out  DATA_WIDTH  last accepted word.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts the word when data_valid && data_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good word dropped because the holding register was full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, counters 0, shift register 0.
  - Outputs: data_out 0, data_valid 0, frame_err 0, overrun 0, busy 0.
  - Synchronizer flops reset to 1.
  - A reset mid-frame abandons the frame with no outputs.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt==CLKS_PER_BIT/2-1, sample rx_s.
    - Sample 0: go to DATA, cnt=0, bit_idx=0.
    - Sample 1: false start, return to IDLE with no outputs.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s and restart cnt.
    - The sample shifts into the MSB end; the register shifts right, so after DATA_WIDTH samples bit0 is in the LSB.
    - After bit_idx==DATA_WIDTH-1 is sampled, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - Sample 1: good word; go to IDLE.
    - Sample 0: frame_err pulses on the next cycle, the word is discarded, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents re-triggering on a held-low line.
- Sampling instants: relative to the first START cycle, samples fall at cycle CLKS_PER_BIT/2-1 + k*CLKS_PER_BIT, for k=0 (start), 1..DATA_WIDTH (data), DATA_WIDTH+1 (stop).
- Holding register handshake:
  - data_valid rises, and data_out loads, the cycle after a good stop sample.
  - Handshake completes on any cycle with data_valid && data_ready. data_valid clears next cycle unless a new word loads that same cycle.
  - data_out is stable while data_valid is high.
  - New good word while data_valid=1 and no handshake that cycle: new word dropped, old word kept, overrun pulses one cycle.
  - New good word in the same cycle as a handshake: new word loads, data_valid stays 1, no overrun.
- frame_err and overrun are mutually exclusive per frame. Neither affects data_valid.
- The receiver never stalls the line. A full holding register only causes drops.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit.
  - Adds output parity_err (1-bit pulse, reset 0). It pulses the cycle after the stop sample when XOR(data bits, parity bit)==1.
  - A parity-failing word is discarded: no data_valid, no overrun.
  - The stop sample moves to k=DATA_WIDTH+2.
- Undefined: no PARITY state, no parity_err port, and the frame is exactly as described above.

Decomposition:
- Package uart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}
  - localparam for the synchronizer depth (2)
  - a function for the half-bit count (CLKS_PER_BIT/2-1)
- One sub-module, uart_rx_bit_timer: a cycle counter with clear input, half_tick and full_tick outputs, parameterized by CLKS_PER_BIT.
- The FSM, shift register and holding register stay in the top module.

Test Plan:
- All tests use DATA_WIDTH=8 and CLKS_PER_BIT=16.
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop 1), data_ready=1 -> data_valid pulses one cycle with data_out=0xA5. frame_err=0, overrun=0.
- Glitch: rx low for 5 cycles, then high -> FSM returns to IDLE. No data_valid, no frame_err, busy drops.
- Frame 0x3C with stop bit 0, then line held low 40 cycles -> frame_err pulses once and no data_valid. Next frame 0x11 after rx returns high -> data_out=0x11.
- data_ready=0, frames 0x01 then 0x02 -> data_out stays 0x01 and data_valid stays 1. overrun pulses once, after the second stop sample.
- Second frame with data_ready pulsed high exactly in the cycle the second word loads -> data_out=0x02, data_valid stays 1, overrun=0.
- reset_n asserted mid-DATA of frame 0xFF, released, then frame 0x5A sent -> all outputs 0 during reset. Only 0x5A is delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types and helpers for the UART receive path
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int SYNC_DEPTH = 2;

  // Counter value at which the middle of a bit period is reached.
  function automatic int half_bit_count(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_timer : per-bit cycle counter with mid-bit and end-of-bit ticks
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit_count(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Wraps on its own at the end of each bit so consecutive bits need no clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign half_tick = (cnt == HALF_CNT);
  assign full_tick = (cnt == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer : LSB-first UART receiver with valid/ready holding reg
// Optional even parity bit enabled by macro UART_RX_PARITY_EN. Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  overrun,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [SYNC_DEPTH-1:0] sync;
  logic                  rx_s;
  rx_state_t             state;
  rx_state_t             state_next;
  logic                  timer_clear;
  logic                  half_tick;
  logic                  full_tick;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_sample;
  logic                  good_word;
  logic                  handshake;

  // Reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], rx};
    end
  end

  assign rx_s = sync[SYNC_DEPTH-1];

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (half_tick) begin
          timer_clear = 1'b1;
          state_next  = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_tick && (bit_idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (full_tick) state_next = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        timer_clear = 1'b1;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    if (DATA_WIDTH > 1) begin : g_shift_wide
      assign shift_next = {rx_s, shift_reg[DATA_WIDTH-1:1]};
    end else begin : g_shift_one
      assign shift_next = rx_s;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bit_idx   <= '0;
    end else if (state == START) begin
      bit_idx <= '0;
    end else if ((state == DATA) && full_tick) begin
      shift_reg <= shift_next;
      bit_idx   <= bit_idx + IDX_W'(1);
    end
  end

  assign stop_sample = (state == STOP) && full_tick;
  assign handshake   = data_valid && data_ready;

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  logic parity_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if ((state == PARITY) && full_tick) parity_bit <= rx_s;
      parity_err <= stop_sample && parity_bad;
    end
  end

  assign parity_bad = ^{shift_reg, parity_bit};
  assign good_word  = stop_sample && rx_s && !parity_bad;
`else
  assign good_word  = stop_sample && rx_s;
`endif

  // A good word loads when the register is empty or is being emptied this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rx_s;
      overrun   <= good_word && data_valid && !data_ready;
      if (good_word && (!data_valid || data_ready)) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
      end else if (handshake) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer : directed and random frames against a frame-level model
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_deserializer;

  localparam int DW  = 8;
  localparam int CPB = 16;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          rx         = 1'b1;
  logic          data_ready = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  int         n_frame_err    = 0;
  int         n_overrun      = 0;
  int         n_valid_cycles = 0;
  logic [7:0] prev_out       = '0;
  logic       prev_hold      = 1'b0;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observes outputs mid-cycle: consumed words, pulse counts, holding stability.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_hold) begin
        checks++;
        assert (data_out === prev_out) else begin
          errors++;
          $error("FAIL hold_stable observed=%0h expected=%0h", data_out, prev_out);
        end
      end
      if (data_valid) n_valid_cycles++;
      if (frame_err) n_frame_err++;
      if (overrun) n_overrun++;
      if (data_valid && data_ready) got_q.push_back(data_out);
      prev_hold = data_valid && !data_ready;
      prev_out  = data_out;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input string tag, input logic [7:0] exp_w);
    logic [31:0] w;
    w = 32'hDEAD_BEEF;
    if (got_q.size() != 0) w = 32'(got_q.pop_front());
    check(tag, w, 32'(exp_w));
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; optionally pulses
  // data_ready for the single cycle in which the stop sample is taken.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int ready_at,
                            input logic [7:0] old_w, input logic [7:0] new_w);
    logic [9:0] bits;
    int t;
    bits = {stop_bit, d, 1'b0};
    t = 0;
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      for (int c = 0; c < CPB; c++) begin
        tick(1);
        t++;
        if (t == ready_at) begin
          check("preload_valid", 32'(data_valid), 1);
          check("preload_data", 32'(data_out), 32'(old_w));
          data_ready = 1'b1;
        end else if (t == ready_at + 1) begin
          check("load_valid", 32'(data_valid), 1);
          check("load_data", 32'(data_out), 32'(new_w));
          data_ready = 1'b0;
        end
      end
    end
  endtask

  int base_v;
  int base_fe;
  int base_ov;

  initial begin
    rx         = 1'b1;
    data_ready = 1'b0;
    reset_n    = 1'b0;
    tick(3);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    tick(5);
    check("idle_busy", 32'(busy), 0);

    // Single good frame with consumer always ready
    data_ready = 1'b1;
    base_v  = n_valid_cycles;
    base_fe = n_frame_err;
    base_ov = n_overrun;
    send_frame(8'hA5, 1'b1, -1, 8'h00, 8'h00);
    rx = 1'b1;
    tick(8);
    expect_word("a5_word", 8'hA5);
    check("a5_valid_cycles", 32'(n_valid_cycles - base_v), 1);
    check("a5_frame_err", 32'(n_frame_err - base_fe), 0);
    check("a5_overrun", 32'(n_overrun - base_ov), 0);
    check("a5_valid_after", 32'(data_valid), 0);

    // Short glitch must be rejected as a false start
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    check("glitch_busy_hi", 32'(busy), 1);
    tick(20);
    check("glitch_busy_lo", 32'(busy), 0);
    check("glitch_no_word", 32'(got_q.size()), 0);
    check("glitch_no_ferr", 32'(n_frame_err - base_fe), 0);

    // Bad stop bit followed by a held-low line
    base_fe = n_frame_err;
    send_frame(8'h3C, 1'b0, -1, 8'h00, 8'h00);
    rx = 1'b0;
    tick(40);
    check("break_busy", 32'(busy), 1);
    check("ferr_once", 32'(n_frame_err - base_fe), 1);
    check("ferr_no_word", 32'(got_q.size()), 0);
    check("ferr_no_valid", 32'(data_valid), 0);
    rx = 1'b1;
    tick(10);
    check("break_exit", 32'(busy), 0);
    send_frame(8'h11, 1'b1, -1, 8'h00, 8'h00);
    rx = 1'b1;
    tick(8);
    expect_word("after_break_word", 8'h11);
    check("ferr_still_once", 32'(n_frame_err - base_fe), 1);

    // Overrun: consumer stalled across two frames
    data_ready = 1'b0;
    base_ov = n_overrun;
    send_frame(8'h01, 1'b1, -1, 8'h00, 8'h00);
    rx = 1'b1;
    tick(4);
    check("ovr_first_valid", 32'(data_valid), 1);
    check("ovr_first_data", 32'(data_out), 'h01);
    send_frame(8'h02, 1'b1, -1, 8'h00, 8'h00);
    rx = 1'b1;
    tick(8);
    check("ovr_kept_data", 32'(data_out), 'h01);
    check("ovr_kept_valid", 32'(data_valid), 1);
    check("ovr_pulse_once", 32'(n_overrun - base_ov), 1);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(1);
    expect_word("ovr_drain", 8'h01);
    check("ovr_drained", 32'(data_valid), 0);

    // Handshake in the same cycle a new word loads
    send_frame(8'h01, 1'b1, -1, 8'h00, 8'h00);
    rx = 1'b1;
    tick(4);
    base_ov = n_overrun;
    send_frame(8'h02, 1'b1, 154, 8'h01, 8'h02);
    rx = 1'b1;
    tick(8);
    check("swap_data", 32'(data_out), 'h02);
    check("swap_valid", 32'(data_valid), 1);
    check("swap_no_overrun", 32'(n_overrun - base_ov), 0);
    expect_word("swap_old_consumed", 8'h01);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(1);
    expect_word("swap_new_consumed", 8'h02);

    // Reset during the data bits of an 0xFF frame
    data_ready = 1'b1;
    base_fe = n_frame_err;
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(40);
    check("midrst_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_valid", 32'(data_valid), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    check("midrst_overrun", 32'(overrun), 0);
    check("midrst_busy_lo", 32'(busy), 0);
    tick(3);
    reset_n = 1'b1;
    tick(20);
    check("postrst_no_word", 32'(got_q.size()), 0);
    send_frame(8'h5A, 1'b1, -1, 8'h00, 8'h00);
    rx = 1'b1;
    tick(8);
    expect_word("postrst_word", 8'h5A);
    check("postrst_only", 32'(got_q.size()), 0);
    check("postrst_no_ferr", 32'(n_frame_err - base_fe), 0);

    // Random frames: model expects every well-stopped byte, one error per bad stop
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      logic       sb;
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        rx = 1'b0;
        tick(int'($urandom_range(1, 6)));
        rx = 1'b1;
        tick(12);
      end
      base_fe = n_frame_err;
      send_frame(d, sb, -1, 8'h00, 8'h00);
      rx = 1'b1;
      tick(int'($urandom_range(4, 20)));
      if (sb) expect_word("rand_word", d);
      check("rand_no_extra", 32'(got_q.size()), 0);
      check("rand_ferr", 32'(n_frame_err - base_fe), sb ? 0 : 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
